fetch_stage: RTL

Instruction-fetch stage plus IF/ID pipeline register of the MIPS datapath, directly upstream of the control unit.
- Holds the PC and issues requests to instruction memory over a req/ready handshake.
- Latches the returned word into the IF/ID register and exposes its opcode field to the control unit.
- Honours stall and flush from the hazard logic, and redirects on taken branches and J/JAL.

---
 rtl/fetch_stage_pkg.sv | 11 +
 rtl/fetch_stage_if_id_reg.sv | 29 ++
 rtl/fetch_stage.sv | 88 ++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared state encoding and instruction-field constants for the fetch stage.
package fetch_stage_pkg;
  typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} fetchState_e;
  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] PC_INC = 32'd4;
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  function automatic logic [5:0] opcodeOf(input logic [31:0] instr);
    return instr[OPC_HI:OPC_LO];
  endfunction
endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register; flush beats load, load beats stall, otherwise a bubble enters.
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        flush,
  input  logic        stall,
  input  logic [31:0] instrIn,
  input  logic [31:0] pcPlus4In,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4
);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      id_valid    <= 1'b0;
      id_instr    <= NOP;
      id_pc_plus4 <= '0;
    end else if (flush || (!load && !stall)) begin
      id_valid <= 1'b0;
      id_instr <= NOP;
    end else if (load) begin
      id_valid    <= 1'b1;
      id_instr    <= instrIn;
      id_pc_plus4 <= pcPlus4In;
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, instruction-memory handshake FSM and IF/ID register with stall, flush and redirect.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4,
  output logic [5:0]  id_opcode
);
  fetchState_e state, nextState;
  logic [31:0] bufInstr, bufPcPlus4, pendingTarget, target, pcPlus4;
  logic        redirect, fetched, park, idLoad, idFlush;
  assign redirect  = branch_taken | jump;
  assign target    = branch_taken ? branch_target : {id_pc_plus4[31:28], jump_index, 2'b00};
  assign pcPlus4   = pc + PC_INC;
  assign fetched   = (state == REQ) && imem_ready;
  assign park      = !redirect && stall && !flush;
  // a plain flush on a returning fetch still lets the correct successor in
  assign idFlush   = redirect | (flush & ~fetched);
  assign idLoad    = (fetched & ~park) | ((state == HOLD) & ~stall);
  assign imem_addr = pc;
  assign id_opcode = opcodeOf(id_instr);
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= nextState;
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    nextState = REQ;
      REQ:     nextState = imem_ready ? (park ? HOLD : REQ) : (redirect ? DRAIN : REQ);
      HOLD:    nextState = (redirect || !(stall || flush)) ? REQ : HOLD;
      DRAIN:   nextState = imem_ready ? REQ : DRAIN;
      default: nextState = IDLE;
    endcase
  end
  always_comb imem_req = (state == REQ) || (state == DRAIN);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pc            <= RESET_PC;
      bufInstr      <= NOP;
      bufPcPlus4    <= '0;
      pendingTarget <= '0;
    end else begin
      case (state)
        REQ:
          if (imem_ready) begin
            pc <= redirect ? target : pcPlus4;
            if (park) begin
              bufInstr   <= imem_rdata;
              bufPcPlus4 <= pcPlus4;
            end
          end else if (redirect) pendingTarget <= target;
        HOLD:
          if (redirect) pc <= target;
        DRAIN:
          if (imem_ready) pc <= redirect ? target : pendingTarget;
          else if (redirect) pendingTarget <= target;
        default: ;
      endcase
    end
  if_id_reg ifId (
    .clk        (clk),
    .reset      (reset),
    .load       (idLoad),
    .flush      (idFlush),
    .stall      (stall),
    .instrIn    (state == HOLD ? bufInstr : imem_rdata),
    .pcPlus4In  (state == HOLD ? bufPcPlus4 : pcPlus4),
    .id_valid   (id_valid),
    .id_instr   (id_instr),
    .id_pc_plus4(id_pc_plus4)
  );
endmodule
